dco_ctrl: RTL

// - Upstream driver of the LC DCO. Converts the loop filter's per-mode tuning words into the
//   row/column/r_all select codes of the Large (5x5), Medium (16x16) and Small (16x16) cap banks.
// - Sequences the PVT -> ACQ -> TRK mode FSM: each mode steers its own bank and freezes the

---
 rtl/dco_ctrl_pkg.sv | 30 +++
 rtl/dco_ctrl_if.sv | 36 +++
 rtl/dco_rc_enc.sv | 33 +++
 rtl/dco_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/dco_ctrl_pkg.sv
// Shared types and constants for the LC DCO bank controller.
package dco_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PVT  = 2'd1,
        ACQ  = 2'd2,
        TRK  = 2'd3
    } mode_t;

    // Bank sizes in cells
    localparam int N_L = 25;
    localparam int N_M = 256;
    localparam int N_S = 256;

    // Matrix widths (rows == columns) of each bank
    localparam int R_L = 5;
    localparam int R_M = 16;
    localparam int R_S = 16;

    // Count widths wide enough to hold a full bank
    localparam int L_CW  = $clog2(N_L + 1);
    localparam int MS_CW = $clog2(N_M + 1);

    // Mid-code counts used at reset and in IDLE
    localparam logic [L_CW-1:0]  L_MID = L_CW'(12);
    localparam logic [MS_CW-1:0] M_MID = MS_CW'(128);
    localparam logic [MS_CW-1:0] S_MID = MS_CW'(128);

endpackage

// File: rtl/dco_ctrl_if.sv
// Tuning/control bus between the loop filter side and the DCO bank controller.
interface dco_ctrl_if #(
    parameter int FRAC_W = 8
);
    logic              en;
    logic              pvt_lock;
    logic              acq_lock;
    logic [4:0]        pvt_word;
    logic [8:0]        acq_word;
    logic [8:0]        trk_word;
    logic [FRAC_W-1:0] trk_frac;
    logic [1:0]        gain_in;

    logic              pd;
    logic [1:0]        osc_gain;
    logic [1:0]        mode;
    logic [4:0]        c_l_r_all, c_l_row, c_l_col;
    logic [15:0]       c_m_r_all, c_m_row, c_m_col;
    logic [15:0]       c_s_r_all, c_s_row, c_s_col;

    modport master (
        output en, pvt_lock, acq_lock, pvt_word, acq_word, trk_word, trk_frac, gain_in,
        input  pd, osc_gain, mode,
        input  c_l_r_all, c_l_row, c_l_col,
        input  c_m_r_all, c_m_row, c_m_col,
        input  c_s_r_all, c_s_row, c_s_col
    );

    modport slave (
        input  en, pvt_lock, acq_lock, pvt_word, acq_word, trk_word, trk_frac, gain_in,
        output pd, osc_gain, mode,
        output c_l_r_all, c_l_row, c_l_col,
        output c_m_r_all, c_m_row, c_m_col,
        output c_s_r_all, c_s_row, c_s_col
    );
endinterface

// File: rtl/dco_rc_enc.sv
// Count -> {r_all,row,col} encoder for an R x R capacitor matrix.
// Whole rows below n/R are switched by r_all; the partial row n/R is
// selected by row and filled from column 0 up to n%R-1 by col.
module dco_rc_enc #(
    parameter int R  = 5,
    parameter int NW = $clog2(R * R + 1)
) (
    input  logic [NW-1:0] n,
    output logic [R-1:0]  r_all,
    output logic [R-1:0]  row,
    output logic [R-1:0]  col
);

    localparam logic [NW-1:0] RV = NW'(R);

    logic [NW-1:0] q;
    logic [NW-1:0] rem;

    // Split the count into full rows and a partial-row remainder, then thermometer-code them
    always_comb begin
        q     = n / RV;
        rem   = n % RV;
        r_all = '0;
        row   = '0;
        col   = '0;
        for (int i = 0; i < R; i++) begin
            r_all[i] = (NW'(i) < q);
            row[i]   = (NW'(i) == q) && (rem != '0);
            col[i]   = (NW'(i) < rem);
        end
    end

endmodule

// File: rtl/dco_ctrl.sv
// LC DCO bank controller: PVT -> ACQ -> TRK mode sequencing, count clamping,
// first-order sigma-delta dither of the tracking fraction, registered bank selects.
module dco_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    dco_ctrl_if.slave  bus
);

    mode_t             state, state_nx;
    logic [L_CW-1:0]   l_cnt, l_nx, l_clamp;
    logic [MS_CW-1:0]  m_cnt, m_nx, m_clamp;
    logic [MS_CW-1:0]  s_cnt, s_nx, s_clamp;
    logic [MS_CW:0]    s_sum;
    logic [FRAC_W-1:0] acc, acc_nx;
    logic [FRAC_W:0]   acc_wide;

    logic [R_L-1:0]    l_r_all, l_row, l_col;
    logic [R_M-1:0]    m_r_all, m_row, m_col;
    logic [R_S-1:0]    s_r_all, s_row, s_col;

    // Saturate incoming words to bank size and form the dithered tracking count
    always_comb begin
        l_clamp  = (bus.pvt_word > L_CW'(N_L)) ? L_CW'(N_L) : bus.pvt_word;
        m_clamp  = (bus.acq_word > MS_CW'(N_M)) ? MS_CW'(N_M) : bus.acq_word;
        acc_wide = {1'b0, acc} + {1'b0, bus.trk_frac};
        s_sum    = {1'b0, bus.trk_word} + (MS_CW + 1)'(acc_wide[FRAC_W]);
        s_clamp  = (s_sum > (MS_CW + 1)'(N_S)) ? MS_CW'(N_S) : s_sum[MS_CW-1:0];
    end

    // Next mode and next bank counts; reset or en=0 force IDLE with mid-code counts
    always_comb begin
        state_nx = state;
        l_nx     = l_cnt;
        m_nx     = m_cnt;
        s_nx     = s_cnt;
        acc_nx   = acc;
        if (rst || !bus.en) begin
            state_nx = IDLE;
            l_nx     = L_MID;
            m_nx     = M_MID;
            s_nx     = S_MID;
            acc_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = PVT;
                    l_nx     = L_MID;
                    m_nx     = M_MID;
                    s_nx     = S_MID;
                end
                PVT: begin
                    l_nx = l_clamp;
                    if (bus.pvt_lock) state_nx = ACQ;
                end
                ACQ: begin
                    m_nx = m_clamp;
                    if (bus.acq_lock) state_nx = TRK;
                end
                TRK: begin
                    acc_nx = acc_wide[FRAC_W-1:0];
                    s_nx   = s_clamp;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Bank counts, dither accumulator, power-down and gain registers
    always_ff @(posedge clk) begin
        if (rst) begin
            l_cnt        <= L_MID;
            m_cnt        <= M_MID;
            s_cnt        <= S_MID;
            acc          <= '0;
            bus.pd       <= 1'b1;
            bus.osc_gain <= 2'd0;
        end else begin
            l_cnt        <= l_nx;
            m_cnt        <= m_nx;
            s_cnt        <= s_nx;
            acc          <= acc_nx;
            bus.pd       <= (state_nx == IDLE);
            bus.osc_gain <= bus.gain_in;
        end
    end

    assign bus.mode = state;

    dco_rc_enc #(.R(R_L)) u_enc_l (.n(l_nx), .r_all(l_r_all), .row(l_row), .col(l_col));
    dco_rc_enc #(.R(R_M)) u_enc_m (.n(m_nx), .r_all(m_r_all), .row(m_row), .col(m_col));
    dco_rc_enc #(.R(R_S)) u_enc_s (.n(s_nx), .r_all(s_r_all), .row(s_row), .col(s_col));

    // Select registers load the encoding of the next counts; under rst those are the mid-codes
    always_ff @(posedge clk) begin
        bus.c_l_r_all <= l_r_all;
        bus.c_l_row   <= l_row;
        bus.c_l_col   <= l_col;
        bus.c_m_r_all <= m_r_all;
        bus.c_m_row   <= m_row;
        bus.c_m_col   <= m_col;
        bus.c_s_r_all <= s_r_all;
        bus.c_s_row   <= s_row;
        bus.c_s_col   <= s_col;
    end

endmodule
